pipe_hazard_sb: RTL and testbench
=================================

PIPE_HAZARD_SB -- requirements
Module: pipe_hazard_sb

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of architectural registers; register address width AW = clog2(NREGS).
REQ-002 SHALL have parameter MC_DEPTH, default 4: maximum outstanding multi-cycle (mul/div) operations, range 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles, at least 2.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall statistics counter.
REQ-005 SHALL have these ports (clock and reset first):
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 rs1_d, rs2_d  in  AW  decode-stage sources
 mc_op_d  in  1  decode instruction is a multi-cycle op
 rs1_e, rs2_e, rd_e  in  AW  execute-stage sources and destination
 load_e  in  1  execute instruction is a load
 pcsrc_e  in  1  taken branch/jump resolved in E
 mc_start_e  in  1  multi-cycle op in E issues to the unit this cycle
 rd_m, rd_w  in  AW  memory and writeback destinations
 regwrite_m, regwrite_w  in  1  M and W write enables
 mc_done  in  1  multi-cycle unit returns a result this cycle
 mc_rd  in  AW  destination of the returning result
 stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls
 forwarda, forwardb  out  2  E operand select: 00 regfile, 01 W, 10 M
 mc_full  out  1  outstanding count equals MC_DEPTH
 timeout_err  out  1  sticky watchdog error
 stall_cnt  out  CNT_W  saturating count of stall_d cycles

Function
REQ-006 forwarda SHALL be 10 when regwrite_m, rd_m==rs1_e and rs1_e!=0; otherwise 01 when regwrite_w, rd_w==rs1_e and rs1_e!=0; otherwise 00. forwardb SHALL follow the same rule with rs2_e; M SHALL win over W.
REQ-007 Load-use hazard: load_e, rd_e!=0 and rd_e equal to rs1_d or rs2_d SHALL assert stall_f, stall_d and flush_e in the same cycle.
REQ-008 SHALL hold a scoreboard of NREGS pending bits, one per register; bit 0 SHALL never be set.
REQ-009 mc_start_e SHALL set pending[rd_e] and increment the outstanding count on the next edge.
REQ-010 mc_done SHALL clear pending[mc_rd] and decrement the outstanding count on the next edge.
REQ-011 mc_start_e and mc_done in the same cycle SHALL leave the count unchanged. If rd_e==mc_rd, the bit SHALL end set (set wins).
REQ-012 Scoreboard hazard: pending[rs1_d] or pending[rs2_d] set SHALL stall F and D and flush E, unless mc_done is high with a matching mc_rd in that cycle (same-cycle release, no stall).
REQ-013 Structural hazard: mc_op_d with count==MC_DEPTH and no mc_done this cycle SHALL stall F and D and flush E.
REQ-014 mc_full SHALL equal (count==MC_DEPTH), registered. mc_start_e while count==MC_DEPTH and no mc_done SHALL be ignored (count not incremented, no bit set).
REQ-015 mc_done while count==0 SHALL be ignored (count stays 0).
REQ-016 pcsrc_e SHALL force flush_d=1, flush_e=1, stall_f=0 and stall_d=0, overriding all stall causes.
REQ-017 Watchdog: a counter SHALL increment each cycle while count>0 and mc_done=0, and clear on mc_done or when count==0. Reaching TIMEOUT SHALL set timeout_err, which stays set until reset.
REQ-018 stall_cnt SHALL increment once per cycle in which stall_d=1 and SHALL saturate at all-ones.
REQ-019 All control outputs SHALL be combinational from the inputs and the registered state, with zero added latency. State updates SHALL take effect on the next rising edge.

Reset
REQ-020 rst_n low SHALL immediately clear the scoreboard, outstanding count, watchdog, timeout_err, mc_full and stall_cnt.
REQ-021 While rst_n is low, stall_f, stall_d, flush_d and flush_e SHALL be 0, and forwarda and forwardb SHALL be 00.
REQ-022 Reset asserted mid-operation SHALL discard all pending entries. After release, no stale stall SHALL occur.

Verification
REQ-023 Forwarding: regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, rs1_e=5 -> forwarda=10. Same with rs1_e=0 -> forwarda=00.
REQ-024 Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle. Next cycle with load_e=0 -> all 0.
REQ-025 Scoreboard: mc_start_e with rd_e=9, then rs1_d=9 -> stall held 3 cycles. mc_done with mc_rd=9 on cycle 4 -> no stall that cycle. stall_cnt=3.
REQ-026 Full: MC_DEPTH=2, two starts -> mc_full=1. mc_op_d=1 -> stall. Simultaneous start and done -> count stays 2.
REQ-027 Branch priority: pending[3] set, rs1_d=3, pcsrc_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
REQ-028 Watchdog/reset: TIMEOUT=8, one start and no done -> timeout_err=1 after 8 cycles. rst_n pulse -> all state 0 and no stall on rs1_d=reg.

Source files
------------

// File: rtl/pipe_hazard_sb.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use detection and a
// register scoreboard that tracks results still owed by the multi-cycle (mul/div) unit.
module pipe_hazard_sb #(
   parameter int NREGS    = 32,
   parameter int MC_DEPTH = 4,
   parameter int TIMEOUT  = 64,
   parameter int CNT_W    = 16,
   localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rs1_d,
   input  logic [AW-1:0]    rs2_d,
   input  logic             mc_op_d,
   input  logic [AW-1:0]    rs1_e,
   input  logic [AW-1:0]    rs2_e,
   input  logic [AW-1:0]    rd_e,
   input  logic             load_e,
   input  logic             pcsrc_e,
   input  logic             mc_start_e,
   input  logic [AW-1:0]    rd_m,
   input  logic [AW-1:0]    rd_w,
   input  logic             regwrite_m,
   input  logic             regwrite_w,
   input  logic             mc_done,
   input  logic [AW-1:0]    mc_rd,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_d,
   output logic             flush_e,
   output logic [1:0]       forwarda,
   output logic [1:0]       forwardb,
   output logic             mc_full,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int CW = $clog2(MC_DEPTH + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH = CW'(MC_DEPTH);
   localparam logic [WW-1:0] TO    = WW'(TIMEOUT);

   logic [NREGS-1:0] pending_q, pending_d;
   logic [CW-1:0]    outCnt_q, outCnt_d;
   logic [WW-1:0]    wdCnt_q, wdCnt_d;
   logic             timeoutErr_q, timeoutErr_d;
   logic             mcFull_q, mcFull_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

   logic isFull, isEmpty, startOk, doneOk;
   logic loadUse, sbHazard, structHazard, anyStall;
   logic release1, release2;

   assign isFull  = (outCnt_q == DEPTH);
   assign isEmpty = (outCnt_q == '0);
   assign doneOk  = mc_done && !isEmpty;
   // A start into a full unit only fits if a result leaves in the same cycle.
   assign startOk = mc_start_e && (!isFull || mc_done);

   always_comb begin
      forwarda = 2'b00;
      forwardb = 2'b00;
      if (rst_n) begin
         if (regwrite_m && (rd_m == rs1_e) && (rs1_e != '0))
            forwarda = 2'b10;
         else if (regwrite_w && (rd_w == rs1_e) && (rs1_e != '0))
            forwarda = 2'b01;
         if (regwrite_m && (rd_m == rs2_e) && (rs2_e != '0))
            forwardb = 2'b10;
         else if (regwrite_w && (rd_w == rs2_e) && (rs2_e != '0))
            forwardb = 2'b01;
      end
   end

   // A returning result releases its register in the cycle it arrives.
   assign release1 = mc_done && (mc_rd == rs1_d);
   assign release2 = mc_done && (mc_rd == rs2_d);

   assign loadUse      = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign sbHazard     = (pending_q[rs1_d] && !release1) || (pending_q[rs2_d] && !release2);
   assign structHazard = mc_op_d && isFull && !mc_done;
   assign anyStall     = loadUse || sbHazard || structHazard;

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (rst_n) begin
         if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (anyStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // Clear before set so that a same-register start and return leave the bit set.
   always_comb begin
      pending_d = pending_q;
      if (doneOk)
         pending_d[mc_rd] = 1'b0;
      if (startOk && (rd_e != '0))
         pending_d[rd_e] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_comb begin
      outCnt_d = outCnt_q;
      case ({startOk, doneOk})
         2'b10:   outCnt_d = outCnt_q + CW'(1);
         2'b01:   outCnt_d = outCnt_q - CW'(1);
         default: outCnt_d = outCnt_q;
      endcase
      mcFull_d = (outCnt_d == DEPTH);
   end

   always_comb begin
      wdCnt_d = wdCnt_q;
      if (mc_done || isEmpty)
         wdCnt_d = '0;
      else if (wdCnt_q != TO)
         wdCnt_d = wdCnt_q + WW'(1);
      timeoutErr_d = timeoutErr_q || (wdCnt_d == TO);
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stall_d && (stallCnt_q != '1))
         stallCnt_d = stallCnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= '0;
         outCnt_q     <= '0;
         wdCnt_q      <= '0;
         timeoutErr_q <= 1'b0;
         mcFull_q     <= 1'b0;
         stallCnt_q   <= '0;
      end else begin
         pending_q    <= pending_d;
         outCnt_q     <= outCnt_d;
         wdCnt_q      <= wdCnt_d;
         timeoutErr_q <= timeoutErr_d;
         mcFull_q     <= mcFull_d;
         stallCnt_q   <= stallCnt_d;
      end
   end

   assign mc_full     = mcFull_q;
   assign timeout_err = timeoutErr_q;
   assign stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Scoreboard-driven bench for pipe_hazard_sb: each scenario queues per-cycle stimulus
// with the controls, mc_full and timeout_err expected in that cycle.
module tb_pipe_hazard_sb;

   localparam int AW = 5;

   typedef struct {
      logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, mcrd;
      logic mcop, load, pcsrc, start, rwm, rww, done;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [7:0] ctrl;
      logic       full;
      logic       err;
   } step_t;

   localparam logic [7:0] NONE   = 8'b0000_0000;
   localparam logic [7:0] STALL  = 8'b1101_0000;
   localparam logic [7:0] BRANCH = 8'b0011_0000;

   logic clk = 1'b0;
   logic rst_n;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_rd;
   logic mc_op_d, load_e, pcsrc_e, mc_start_e, regwrite_m, regwrite_w, mc_done;
   logic stall_f, stall_d, flush_d, flush_e, mc_full, timeout_err;
   logic [1:0] forwarda, forwardb;
   logic [3:0] stall_cnt;
   logic [7:0] ctrlObs;

   int compared = 0;
   int mismatched = 0;
   logic [3:0] expStall = '0;
   step_t planQ[$];
   step_t expQ[$];

   assign ctrlObs = {stall_f, stall_d, flush_d, flush_e, forwarda, forwardb};

   always #5 clk = ~clk;

   pipe_hazard_sb #(.NREGS(32), .MC_DEPTH(2), .TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .mc_op_d(mc_op_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .load_e(load_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
      .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .mc_done(mc_done), .mc_rd(mc_rd),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .forwarda(forwarda), .forwardb(forwardb),
      .mc_full(mc_full), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
   );

   function automatic stim_t idleStim();
      stim_t s;
      s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0; s.rde = '0;
      s.rdm = '0; s.rdw = '0; s.mcrd = '0;
      s.mcop = 1'b0; s.load = 1'b0; s.pcsrc = 1'b0; s.start = 1'b0;
      s.rwm = 1'b0; s.rww = 1'b0; s.done = 1'b0;
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      rs1_d = s.rs1d; rs2_d = s.rs2d; mc_op_d = s.mcop;
      rs1_e = s.rs1e; rs2_e = s.rs2e; rd_e = s.rde;
      load_e = s.load; pcsrc_e = s.pcsrc; mc_start_e = s.start;
      rd_m = s.rdm; rd_w = s.rdw; regwrite_m = s.rwm; regwrite_w = s.rww;
      mc_done = s.done; mc_rd = s.mcrd;
   endtask

   task automatic plan(input stim_t s, input logic [7:0] c, input logic f, input logic e);
      step_t p;
      p.s = s; p.ctrl = c; p.full = f; p.err = e;
      planQ.push_back(p);
   endtask

   task automatic applyReset();
      applyStimulus(idleStim());
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      expStall = '0;
   endtask

   task automatic test_reset();
      stim_t s;
      s = idleStim();
      s.load = 1'b1; s.rde = 5'd7; s.rs1d = 5'd7; s.rwm = 1'b1; s.rdm = 5'd5; s.rs1e = 5'd5; s.pcsrc = 1'b1;
      rst_n = 1'b0;
      applyStimulus(s);
      #3;
      compared++;
      if (ctrlObs !== NONE) begin mismatched++; $display("[TB] FAIL reset ctrl: got %b want %b", ctrlObs, NONE); end
      compared++;
      if ({mc_full, timeout_err, stall_cnt} !== 6'b0) begin
         mismatched++; $display("[TB] FAIL reset state: full=%b err=%b cnt=%0d want 0", mc_full, timeout_err, stall_cnt);
      end
      @(negedge clk);
      applyStimulus(idleStim());
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_forwarding();
      stim_t s;
      step_t e;
      int idx = 0;
      s = idleStim(); s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; plan(s, 8'b0000_1000, 0, 0);
      s.rs1e = 0;                                                              plan(s, NONE, 0, 0);
      s = idleStim(); s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 5; plan(s, 8'b0000_0101, 0, 0);
      s = idleStim(); s.rwm = 1; s.rdm = 6; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 6; plan(s, 8'b0000_0110, 0, 0);
      s = idleStim(); s.rwm = 1; s.rdm = 31; s.rdw = 31; s.rs1e = 31; s.rs2e = 31; plan(s, 8'b0000_1010, 0, 0);
      s = idleStim(); s.rdm = 5; s.rdw = 5; s.rs1e = 5; s.rs2e = 5;             plan(s, NONE, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL fwd ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         compared++;
         if ({mc_full, timeout_err} !== {e.full, e.err}) begin
            mismatched++; $display("[TB] FAIL fwd state step %0d: got %b%b want %b%b", idx, mc_full, timeout_err, e.full, e.err);
         end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
      end
   endtask

   task automatic test_load_use();
      stim_t s;
      step_t e;
      int idx = 0;
      s = idleStim(); s.load = 1; s.rde = 7; s.rs2d = 7;   plan(s, STALL, 0, 0);
      s.load = 0;                                           plan(s, NONE, 0, 0);
      s = idleStim(); s.load = 1;                           plan(s, NONE, 0, 0);
      s = idleStim(); s.load = 1; s.rde = 12; s.rs1d = 12; s.rs2d = 3; plan(s, STALL, 0, 0);
      s.rs1d = 4; s.rs2d = 5;                               plan(s, NONE, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL loaduse ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
      end
      compared++;
      if (stall_cnt !== expStall) begin mismatched++; $display("[TB] FAIL loaduse stall_cnt: got %0d want %0d", stall_cnt, expStall); end
   endtask

   task automatic test_scoreboard();
      stim_t s;
      step_t e;
      int idx = 0;
      applyReset();
      s = idleStim(); s.start = 1; s.rde = 9;           plan(s, NONE, 0, 0);
      s = idleStim(); s.rs1d = 9;                        plan(s, STALL, 0, 0);
      plan(s, STALL, 0, 0);
      plan(s, STALL, 0, 0);
      s.done = 1; s.mcrd = 9;                            plan(s, NONE, 0, 0);
      s = idleStim(); s.rs1d = 9;                        plan(s, NONE, 0, 0);
      s = idleStim(); s.start = 1; s.rde = 4;            plan(s, NONE, 0, 0);
      s.done = 1; s.mcrd = 4;                            plan(s, NONE, 0, 0);
      s = idleStim(); s.rs2d = 4;                        plan(s, STALL, 0, 0);
      s.done = 1; s.mcrd = 4;                            plan(s, NONE, 0, 0);
      s = idleStim(); s.rs2d = 4;                        plan(s, NONE, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL sb ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         compared++;
         if (mc_full !== e.full) begin mismatched++; $display("[TB] FAIL sb full step %0d: got %b want %b", idx, mc_full, e.full); end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
         if (idx == 5) begin
            compared++;
            if (stall_cnt !== 4'd3) begin mismatched++; $display("[TB] FAIL sb stall_cnt: got %0d want 3", stall_cnt); end
         end
      end
   endtask

   task automatic test_full();
      stim_t s;
      step_t e;
      int idx = 0;
      applyReset();
      s = idleStim(); s.start = 1; s.rde = 10;                          plan(s, NONE, 0, 0);
      s.rde = 11;                                                        plan(s, NONE, 0, 0);
      s = idleStim(); s.mcop = 1;                                        plan(s, STALL, 1, 0);
      s.done = 1; s.mcrd = 10; s.start = 1; s.rde = 12;                  plan(s, NONE, 1, 0);
      s = idleStim(); s.start = 1; s.rde = 13;                           plan(s, NONE, 1, 0);
      s = idleStim(); s.rs1d = 13;                                       plan(s, NONE, 1, 0);
      s = idleStim(); s.rs2d = 12;                                       plan(s, STALL, 1, 0);
      s = idleStim(); s.done = 1; s.mcrd = 11;                           plan(s, NONE, 1, 0);
      s = idleStim(); s.done = 1; s.mcrd = 12; s.rs1d = 12;              plan(s, NONE, 0, 0);
      s = idleStim(); s.done = 1; s.mcrd = 5;                            plan(s, NONE, 0, 0);
      s = idleStim(); s.start = 1; s.rde = 14;                           plan(s, NONE, 0, 0);
      s.rde = 15;                                                        plan(s, NONE, 0, 0);
      s = idleStim(); s.mcop = 1;                                        plan(s, STALL, 1, 0);
      s = idleStim(); s.done = 1; s.mcrd = 14;                           plan(s, NONE, 1, 0);
      s.mcrd = 15;                                                       plan(s, NONE, 0, 0);
      s = idleStim();                                                    plan(s, NONE, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL full ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         compared++;
         if (mc_full !== e.full) begin mismatched++; $display("[TB] FAIL full mc_full step %0d: got %b want %b", idx, mc_full, e.full); end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
      end
      compared++;
      if (stall_cnt !== expStall) begin mismatched++; $display("[TB] FAIL full stall_cnt: got %0d want %0d", stall_cnt, expStall); end
   endtask

   task automatic test_branch();
      stim_t s;
      step_t e;
      int idx = 0;
      applyReset();
      s = idleStim(); s.start = 1; s.rde = 3;                            plan(s, NONE, 0, 0);
      s = idleStim(); s.rs1d = 3; s.pcsrc = 1;                           plan(s, BRANCH, 0, 0);
      s.load = 1; s.rde = 3; s.rwm = 1; s.rdm = 6; s.rs1e = 6; s.mcop = 1; plan(s, 8'b0011_1000, 0, 0);
      s = idleStim(); s.rs1d = 3;                                        plan(s, STALL, 0, 0);
      s.done = 1; s.mcrd = 3;                                            plan(s, NONE, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL branch ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
      end
      compared++;
      if (stall_cnt !== expStall) begin mismatched++; $display("[TB] FAIL branch stall_cnt: got %0d want %0d", stall_cnt, expStall); end
   endtask

   task automatic test_watchdog();
      stim_t s;
      step_t e;
      int idx = 0;
      applyReset();
      s = idleStim(); s.start = 1; s.rde = 20;                           plan(s, NONE, 0, 0);
      s = idleStim();
      for (int k = 1; k <= 10; k++) plan(s, NONE, 0, (k >= 9));
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (timeout_err !== e.err) begin mismatched++; $display("[TB] FAIL wdog err step %0d: got %b want %b", idx, timeout_err, e.err); end
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL wdog ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         @(posedge clk); #1;
         idx++;
      end
      s = idleStim(); s.rs1d = 20; s.load = 1; s.rde = 20; s.pcsrc = 1; s.rwm = 1; s.rdm = 2; s.rs2e = 2;
      applyStimulus(s);
      rst_n = 1'b0;
      #1;
      compared++;
      if ({ctrlObs, mc_full, timeout_err, stall_cnt} !== 14'b0) begin
         mismatched++; $display("[TB] FAIL wdog in-reset: ctrl=%b full=%b err=%b cnt=%0d want all 0", ctrlObs, mc_full, timeout_err, stall_cnt);
      end
      #1;
      rst_n = 1'b1;
      applyStimulus(idleStim());
      expStall = '0;
      @(posedge clk); #1;
      s = idleStim(); s.rs1d = 20; s.mcop = 1;
      applyStimulus(s);
      @(negedge clk);
      compared++;
      if ({ctrlObs, mc_full, timeout_err} !== 10'b0) begin
         mismatched++; $display("[TB] FAIL wdog after reset: ctrl=%b full=%b err=%b want all 0", ctrlObs, mc_full, timeout_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      stim_t s;
      step_t e;
      int idx = 0;
      applyReset();
      s = idleStim(); s.load = 1; s.rde = 7; s.rs1d = 7;
      for (int k = 0; k < 20; k++) plan(s, STALL, 0, 0);
      while (planQ.size() > 0) begin
         e = planQ.pop_front();
         applyStimulus(e.s);
         expQ.push_back(e);
         @(negedge clk);
         e = expQ.pop_front();
         compared++;
         if (ctrlObs !== e.ctrl) begin mismatched++; $display("[TB] FAIL b2b ctrl step %0d: got %b want %b", idx, ctrlObs, e.ctrl); end
         if (e.ctrl[6] && expStall != 4'hF) expStall++;
         @(posedge clk); #1;
         idx++;
      end
      applyStimulus(idleStim());
      @(negedge clk);
      compared++;
      if (stall_cnt !== expStall) begin mismatched++; $display("[TB] FAIL b2b saturated stall_cnt: got %0d want %0d", stall_cnt, expStall); end
   endtask

   initial begin
      $display("[TB] starting pipe_hazard_sb bench");
      test_reset();
      test_forwarding();
      test_load_use();
      test_scoreboard();
      test_full();
      test_branch();
      test_watchdog();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
